audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx_pkg.sv | 11 +
 rtl/audio_clk_div.sv | 31 +++
 rtl/audio_i2s_tx.sv | 110 +++++++++++
 tb/tb_audio_i2s_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio definitions: default sample width and I2S frame geometry.
package audio_i2s_tx_pkg;

  localparam int AUDIO_DW_DEF = 16;
  localparam int I2S_SLOTS = 2 * AUDIO_DW_DEF;

  function automatic int i2s_slots(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/audio_clk_div.sv
// SCK generator: toggles every CLK_DIV clk, strobes the 1->0 cycle.
module audio_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(CLK_DIV - 1));
  assign fall = wrap & sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S stereo transmitter with a one-deep sample holding register.
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AUDIO_DW-1:0] left_in,
  input  logic [AUDIO_DW-1:0] right_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_sck,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                underrun
);

  localparam int SLOTS = i2s_slots(AUDIO_DW);
  localparam int SW    = $clog2(SLOTS);
  localparam int BW    = (AUDIO_DW > 1) ? $clog2(AUDIO_DW) : 1;

  logic [SW-1:0]       slot;
  logic [SW-1:0]       nslot;
  logic [BW-1:0]       bidx;
  logic                tick;
  logic                load;
  logic                full;
  logic                accept;
  logic                sd_n;
  logic                ws_n;
  logic [AUDIO_DW-1:0] hold_l;
  logic [AUDIO_DW-1:0] hold_r;
  logic [AUDIO_DW-1:0] frame_l;
  logic [AUDIO_DW-1:0] frame_r;
  logic [AUDIO_DW-1:0] nl;
  logic [AUDIO_DW-1:0] nr;

  audio_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (i2s_sck),
    .fall (tick)
  );

  assign sample_ready = ~full;
  assign accept = sample_valid & ~full;

  assign nslot = (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;
  assign load  = tick & (nslot == '0);

  // An empty holding register at load keeps the old frame (repeat).
  assign nl = (load & full) ? hold_l : frame_l;
  assign nr = (load & full) ? hold_r : frame_r;

  always_comb begin
    bidx = '0;
    sd_n = 1'b0;
    if (nslot < SW'(AUDIO_DW)) begin
      bidx = BW'(SW'(AUDIO_DW - 1) - nslot);
      sd_n = nl[bidx];
    end else begin
      bidx = BW'(SW'(SLOTS - 1) - nslot);
      sd_n = nr[bidx];
    end
  end

  assign ws_n = (nslot >= SW'(AUDIO_DW - 1)) &&
                (nslot <= SW'(SLOTS - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= SW'(SLOTS - 1);
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      frame_l  <= '0;
      frame_r  <= '0;
      i2s_sd   <= 1'b0;
      i2s_ws   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (tick) begin
        slot   <= nslot;
        i2s_sd <= sd_n;
        i2s_ws <= ws_n;
        if (load) begin
          frame_l <= nl;
          frame_r <= nr;
        end
      end
      if (load && full) begin
        full <= 1'b0;
      end else begin
        if (load)
          underrun <= 1'b1;
        if (accept) begin
          hold_l <= left_in;
          hold_r <= right_in;
          full   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with CLK_DIV=2, 16-bit samples.
module tb_audio_i2s_tx;

  localparam int DW  = 16;
  localparam int DIV = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] left_in = '0;
  logic [DW-1:0] right_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          i2s_sck;
  logic          i2s_ws;
  logic          i2s_sd;
  logic          underrun;

  int total = 0;
  int bad = 0;
  int tslot = 31;
  int cyc = 0;
  int last_fall = 0;
  int period = 0;
  int ucnt = 0;
  int acnt = 0;
  int rhi = 0;
  bit sckq = 1'b0;
  bit fell = 1'b0;
  bit autoinc = 1'b0;

  logic [DW-1:0] fl;
  logic [DW-1:0] fr;
  logic [31:0]   fw;

  audio_i2s_tx #(
    .AUDIO_DW(DW),
    .CLK_DIV (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_in     (left_in),
    .right_in    (right_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_sck     (i2s_sck),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (i2s_sd),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc;
    acc = sample_valid && sample_ready;
    @(posedge clk);
    #1;
    cyc++;
    fell = sckq && !i2s_sck;
    sckq = i2s_sck;
    if (fell) begin
      period = cyc - last_fall;
      last_fall = cyc;
      tslot = (tslot + 1) % 32;
    end
    if (underrun) ucnt++;
    if (sample_ready) rhi++;
    if (acc) begin
      acnt++;
      if (autoinc) begin
        left_in = left_in + 16'h0101;
        right_in = right_in - 16'h0101;
      end
    end
  endtask

  task automatic next_fall();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!fell && n < 40);
    if (!fell) begin
      total++;
      bad++;
      $error("FAIL fall_timeout: observed no sck fall expected one");
    end
  endtask

  task automatic get_frame(output logic [DW-1:0] l,
                           output logic [DW-1:0] r,
                           output logic [31:0] w);
    l = '0;
    r = '0;
    w = '0;
    for (int s = 0; s < 32; s++) begin
      next_fall();
      if (s < 16) l[15-s] = i2s_sd;
      else r[31-s] = i2s_sd;
      w[s] = i2s_ws;
    end
  endtask

  task automatic clr();
    ucnt = 0;
    acnt = 0;
    rhi = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sckq = 1'b0;
    tslot = 31;
  endtask

  task automatic accept_one(input logic [DW-1:0] l,
                            input logic [DW-1:0] r);
    left_in = l;
    right_in = r;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_sck", 64'(i2s_sck), 64'd0);
    chk("rst_ws", 64'(i2s_ws), 64'd0);
    chk("rst_sd", 64'(i2s_sd), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_ready", 64'(sample_ready), 64'd1);
    do_reset();

    // 8001/7FFE accepted before the first wrap
    accept_one(16'h8001, 16'h7FFE);
    chk("acc_ready_low", 64'(sample_ready), 64'd0);
    clr();
    get_frame(fl, fr, fw);
    chk("f0_left", 64'(fl), 64'h8001);
    chk("f0_right", 64'(fr), 64'h7FFE);
    chk("f0_ws", 64'(fw), 64'h7FFF8000);
    chk("sck_period", 64'(period), 64'd4);
    chk("f0_underrun", 64'(ucnt), 64'd0);
    clr();
    get_frame(fl, fr, fw);
    chk("f1_rep_left", 64'(fl), 64'h8001);
    chk("f1_rep_right", 64'(fr), 64'h7FFE);
    chk("f1_underrun", 64'(ucnt), 64'd1);

    // no samples: zero frames, one underrun each, ready always high
    do_reset();
    for (int f = 0; f < 2; f++) begin
      clr();
      get_frame(fl, fr, fw);
      chk("zero_frame", 64'({fl, fr}), 64'd0);
      chk("zero_underrun", 64'(ucnt), 64'd1);
      chk("zero_ready_cycles", 64'(rhi), 64'd128);
    end

    // single accept repeated forever
    do_reset();
    accept_one(16'h1234, 16'hABCD);
    clr();
    get_frame(fl, fr, fw);
    chk("one_f0", 64'({fl, fr}), 64'h1234ABCD);
    chk("one_f0_underrun", 64'(ucnt), 64'd0);
    for (int f = 0; f < 2; f++) begin
      clr();
      get_frame(fl, fr, fw);
      chk("one_rep", 64'({fl, fr}), 64'h1234ABCD);
      chk("one_rep_underrun", 64'(ucnt), 64'd1);
    end

    // valid held high: one accept per frame
    do_reset();
    autoinc = 1'b1;
    left_in = 16'h1000;
    right_in = 16'h2000;
    sample_valid = 1'b1;
    get_frame(fl, fr, fw);
    chk("cont_f0", 64'({fl, fr}), 64'h10002000);
    clr();
    get_frame(fl, fr, fw);
    chk("cont_f1", 64'({fl, fr}), 64'h11011EFF);
    chk("cont_accepts", 64'(acnt), 64'd1);
    chk("cont_underrun", 64'(ucnt), 64'd0);
    chk("cont_ready_cycles", 64'(rhi), 64'd1);
    clr();
    get_frame(fl, fr, fw);
    chk("cont_f2", 64'({fl, fr}), 64'h12021DFE);
    chk("cont_accepts2", 64'(acnt), 64'd1);
    sample_valid = 1'b0;
    autoinc = 1'b0;

    // accept coinciding with an empty-holding load
    do_reset();
    get_frame(fl, fr, fw);
    step();
    step();
    step();
    clr();
    accept_one(16'h5A5A, 16'hC3C3);
    chk("coin_fell", 64'(fell), 64'd1);
    chk("coin_slot", 64'(tslot), 64'd0);
    chk("coin_underrun", 64'(ucnt), 64'd1);
    chk("coin_accept", 64'(acnt), 64'd1);
    chk("coin_ready", 64'(sample_ready), 64'd0);
    for (int s = 1; s < 32; s++) next_fall();
    clr();
    get_frame(fl, fr, fw);
    chk("coin_next", 64'({fl, fr}), 64'h5A5AC3C3);
    chk("coin_next_underrun", 64'(ucnt), 64'd0);

    // reset mid-frame at slot 10
    do_reset();
    accept_one(16'hFFFF, 16'hFFFF);
    for (int s = 0; s < 11; s++) next_fall();
    chk("mid_slot", 64'(tslot), 64'd10);
    step();
    step();
    chk("mid_pre_sck", 64'(i2s_sck), 64'd1);
    chk("mid_pre_sd", 64'(i2s_sd), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'({i2s_sck, i2s_ws, i2s_sd, underrun}), 64'd0);
    chk("mid_rst_ready", 64'(sample_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sckq = 1'b0;
    tslot = 31;
    clr();
    get_frame(fl, fr, fw);
    chk("restart_zero", 64'({fl, fr}), 64'd0);
    chk("restart_underrun", 64'(ucnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
